// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped one-word-line instruction cache between fetch and the memory controller
// Hits answer one cycle after acceptance; misses block until the single outstanding refill returns.
module icache #(
   parameter int INDEX_WIDTH = 8,
   parameter int ADDR_WIDTH  = 32
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  if_icache_en_in,
   input  logic [ADDR_WIDTH-1:0] if_icache_inst_addr_in,
   output logic                  icache_if_rdy_out,
   output logic                  icache_if_miss_out,
   output logic [31:0]           icache_if_inst_out,
   input  logic                  rob_icache_clear_in,
   output logic                  icache_memctrl_en_out,
   output logic [ADDR_WIDTH-1:0] icache_memctrl_addr_out,
   input  logic                  memctrl_icache_rdy_in,
   input  logic [31:0]           memctrl_icache_inst_in
);

   localparam int DEPTH = 1 << INDEX_WIDTH;
   localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH - 2;
   localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

   typedef enum logic {
      S_IDLE,
      S_MISS
   } state_t;

   state_t                  state;
   logic                    drop_q;
   logic [DEPTH-1:0]        valid_q;
   logic [TAG_W-1:0]        tag_q  [DEPTH];
   logic [31:0]             data_q [DEPTH];

   logic [INDEX_WIDTH-1:0]  req_idx;
   logic [TAG_W-1:0]        req_tag;
   logic [INDEX_WIDTH-1:0]  fill_idx;
   logic [TAG_W-1:0]        fill_tag;
   logic                    req_hit;
   logic                    req_accept;
   logic                    fill_we;

   assign req_idx    = if_icache_inst_addr_in[INDEX_WIDTH+1:2];
   assign req_tag    = if_icache_inst_addr_in[ADDR_WIDTH-1:INDEX_WIDTH+2];
   // The refill target comes from the registered request address, which holds through MISS.
   assign fill_idx   = icache_memctrl_addr_out[INDEX_WIDTH+1:2];
   assign fill_tag   = icache_memctrl_addr_out[ADDR_WIDTH-1:INDEX_WIDTH+2];
   assign req_hit    = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign req_accept = if_icache_en_in && icache_if_rdy_out && !rob_icache_clear_in;
   assign fill_we    = !rst_in && rdy_in && (state == S_MISS) && memctrl_icache_rdy_in;

   always_ff @(posedge clk_in) begin
      if (fill_we) begin
         data_q[fill_idx] <= memctrl_icache_inst_in;
         tag_q[fill_idx]  <= fill_tag;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state                   <= S_IDLE;
         drop_q                  <= 1'b0;
         valid_q                 <= '0;
         icache_if_rdy_out       <= 1'b1;
         icache_if_miss_out      <= 1'b1;
         icache_if_inst_out      <= 32'h0;
         icache_memctrl_en_out   <= 1'b0;
         icache_memctrl_addr_out <= '0;
      end else if (rdy_in) begin
         case (state)
            S_IDLE: begin
               icache_if_miss_out <= 1'b1;
               if (req_accept) begin
                  if (req_hit) begin
                     icache_if_miss_out <= 1'b0;
                     icache_if_inst_out <= data_q[req_idx];
                  end else begin
                     icache_if_rdy_out       <= 1'b0;
                     icache_memctrl_en_out   <= 1'b1;
                     icache_memctrl_addr_out <= if_icache_inst_addr_in & WORD_MASK;
                     drop_q                  <= 1'b0;
                     state                   <= S_MISS;
                  end
               end
            end
            S_MISS: begin
               icache_if_miss_out <= 1'b1;
               if (rob_icache_clear_in) begin
                  drop_q <= 1'b1;
               end
               // A flush never cancels the refill: the line is always written.
               if (memctrl_icache_rdy_in) begin
                  valid_q[fill_idx]     <= 1'b1;
                  icache_memctrl_en_out <= 1'b0;
                  icache_if_rdy_out     <= 1'b1;
                  state                 <= S_IDLE;
                  if (!drop_q && !rob_icache_clear_in) begin
                     icache_if_miss_out <= 1'b0;
                     icache_if_inst_out <= memctrl_icache_inst_in;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - self-checking bench for icache
// Directed scenarios followed by random traffic checked against a resident-line model.
module tb_icache;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        if_icache_en_in;
   logic [31:0] if_icache_inst_addr_in;
   logic        icache_if_rdy_out;
   logic        icache_if_miss_out;
   logic [31:0] icache_if_inst_out;
   logic        rob_icache_clear_in;
   logic        icache_memctrl_en_out;
   logic [31:0] icache_memctrl_addr_out;
   logic        memctrl_icache_rdy_in;
   logic [31:0] memctrl_icache_inst_in;

   int checks = 0;
   int errors = 0;

   // Model: which word address each index currently holds.
   bit          m_v    [256];
   logic [31:0] m_addr [256];

   always #5 clk_in = ~clk_in;

   icache dut (
      .clk_in                  (clk_in),
      .rst_in                  (rst_in),
      .rdy_in                  (rdy_in),
      .if_icache_en_in         (if_icache_en_in),
      .if_icache_inst_addr_in  (if_icache_inst_addr_in),
      .icache_if_rdy_out       (icache_if_rdy_out),
      .icache_if_miss_out      (icache_if_miss_out),
      .icache_if_inst_out      (icache_if_inst_out),
      .rob_icache_clear_in     (rob_icache_clear_in),
      .icache_memctrl_en_out   (icache_memctrl_en_out),
      .icache_memctrl_addr_out (icache_memctrl_addr_out),
      .memctrl_icache_rdy_in   (memctrl_icache_rdy_in),
      .memctrl_icache_inst_in  (memctrl_icache_inst_in)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] w;
      w = a & 32'hFFFF_FFFC;
      if (w == 32'h0000_1000) return 32'h00A0_0093;
      return (w * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset();
      rst_in = 1'b1;
      step();
      step();
      rst_in = 1'b0;
      for (int i = 0; i < 256; i++) m_v[i] = 1'b0;
   endtask

   task automatic issue(input logic [31:0] a);
      if_icache_en_in        = 1'b1;
      if_icache_inst_addr_in = a;
      step();
      if_icache_en_in        = 1'b0;
   endtask

   task automatic refill(input int lat, input logic [31:0] w);
      repeat (lat) step();
      memctrl_icache_rdy_in  = 1'b1;
      memctrl_icache_inst_in = w;
      step();
      memctrl_icache_rdy_in  = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (icache_if_rdy_out !== 1'b1 || icache_if_miss_out !== 1'b1) begin
         errors++; $display("FAIL reset_hs rdy=%b miss=%b required 1 1", icache_if_rdy_out, icache_if_miss_out);
      end
      checks++;
      if (icache_if_inst_out !== 32'h0) begin
         errors++; $display("FAIL reset_inst got=%h required 0", icache_if_inst_out);
      end
      checks++;
      if (icache_memctrl_en_out !== 1'b0 || icache_memctrl_addr_out !== 32'h0) begin
         errors++; $display("FAIL reset_mem en=%b addr=%h required 0 0", icache_memctrl_en_out, icache_memctrl_addr_out);
      end
   endtask

   task automatic test_first_miss();
      issue(32'h0000_1000);
      checks++;
      if (icache_if_miss_out !== 1'b1 || icache_if_rdy_out !== 1'b0 || icache_memctrl_en_out !== 1'b1
          || icache_memctrl_addr_out !== 32'h0000_1000) begin
         errors++; $display("FAIL first_miss_req miss=%b rdy=%b en=%b addr=%h required 1 0 1 00001000",
                            icache_if_miss_out, icache_if_rdy_out, icache_memctrl_en_out, icache_memctrl_addr_out);
      end
      repeat (3) step();
      checks++;
      if (icache_memctrl_en_out !== 1'b1 || icache_memctrl_addr_out !== 32'h0000_1000 || icache_if_rdy_out !== 1'b0) begin
         errors++; $display("FAIL first_miss_hold en=%b addr=%h rdy=%b", icache_memctrl_en_out, icache_memctrl_addr_out, icache_if_rdy_out);
      end
      refill(0, 32'h00A0_0093);
      checks++;
      if (icache_if_miss_out !== 1'b0 || icache_if_inst_out !== 32'h00A0_0093 || icache_memctrl_en_out !== 1'b0) begin
         errors++; $display("FAIL first_miss_resp miss=%b inst=%h en=%b required 0 00a00093 0",
                            icache_if_miss_out, icache_if_inst_out, icache_memctrl_en_out);
      end
      step();
      checks++;
      if (icache_if_miss_out !== 1'b1 || icache_if_rdy_out !== 1'b1) begin
         errors++; $display("FAIL first_miss_pulse miss=%b rdy=%b required 1 1", icache_if_miss_out, icache_if_rdy_out);
      end
   endtask

   task automatic test_back_to_back();
      issue(32'h0000_1004);
      refill(1, mem_word(32'h0000_1004));
      step();
      if_icache_en_in        = 1'b1;
      if_icache_inst_addr_in = 32'h0000_1000;
      step();
      checks++;
      if (icache_if_miss_out !== 1'b0 || icache_if_inst_out !== 32'h00A0_0093 || icache_memctrl_en_out !== 1'b0) begin
         errors++; $display("FAIL b2b_first miss=%b inst=%h en=%b required 0 00a00093 0",
                            icache_if_miss_out, icache_if_inst_out, icache_memctrl_en_out);
      end
      if_icache_inst_addr_in = 32'h0000_1004;
      step();
      if_icache_en_in = 1'b0;
      checks++;
      if (icache_if_miss_out !== 1'b0 || icache_if_inst_out !== mem_word(32'h0000_1004) || icache_memctrl_en_out !== 1'b0) begin
         errors++; $display("FAIL b2b_second miss=%b inst=%h required 0 %h",
                            icache_if_miss_out, icache_if_inst_out, mem_word(32'h0000_1004));
      end
      step();
      checks++;
      if (icache_if_miss_out !== 1'b1) begin
         errors++; $display("FAIL b2b_end miss=%b required 1", icache_if_miss_out);
      end
   endtask

   task automatic test_alias();
      issue(32'h0000_1400);
      checks++;
      if (icache_if_miss_out !== 1'b1 || icache_memctrl_en_out !== 1'b1 || icache_memctrl_addr_out !== 32'h0000_1400) begin
         errors++; $display("FAIL alias_miss en=%b addr=%h required 1 00001400", icache_memctrl_en_out, icache_memctrl_addr_out);
      end
      refill(2, mem_word(32'h0000_1400));
      checks++;
      if (icache_if_miss_out !== 1'b0 || icache_if_inst_out !== mem_word(32'h0000_1400)) begin
         errors++; $display("FAIL alias_fill miss=%b inst=%h required 0 %h", icache_if_miss_out, icache_if_inst_out, mem_word(32'h0000_1400));
      end
      step();
      issue(32'h0000_1000);
      checks++;
      if (icache_if_miss_out !== 1'b1 || icache_memctrl_en_out !== 1'b1 || icache_memctrl_addr_out !== 32'h0000_1000) begin
         errors++; $display("FAIL alias_evict en=%b addr=%h required 1 00001000", icache_memctrl_en_out, icache_memctrl_addr_out);
      end
      refill(0, 32'h00A0_0093);
      step();
   endtask

   task automatic test_clear();
      issue(32'h0000_2000);
      rob_icache_clear_in = 1'b1;
      step();
      rob_icache_clear_in = 1'b0;
      checks++;
      if (icache_memctrl_en_out !== 1'b1 || icache_memctrl_addr_out !== 32'h0000_2000) begin
         errors++; $display("FAIL clear_keep_req en=%b addr=%h required 1 00002000", icache_memctrl_en_out, icache_memctrl_addr_out);
      end
      refill(1, mem_word(32'h0000_2000));
      checks++;
      if (icache_if_miss_out !== 1'b1 || icache_if_rdy_out !== 1'b1 || icache_memctrl_en_out !== 1'b0) begin
         errors++; $display("FAIL clear_drop miss=%b rdy=%b en=%b required 1 1 0",
                            icache_if_miss_out, icache_if_rdy_out, icache_memctrl_en_out);
      end
      issue(32'h0000_2000);
      checks++;
      if (icache_if_miss_out !== 1'b0 || icache_if_inst_out !== mem_word(32'h0000_2000) || icache_memctrl_en_out !== 1'b0) begin
         errors++; $display("FAIL clear_fill_kept miss=%b inst=%h required 0 %h", icache_if_miss_out, icache_if_inst_out, mem_word(32'h0000_2000));
      end
      step();
   endtask

   task automatic test_freeze();
      issue(32'h0000_2000);
      rdy_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (icache_if_miss_out !== 1'b0 || icache_if_inst_out !== mem_word(32'h0000_2000)) begin
            errors++; $display("FAIL freeze_hit cyc=%0d miss=%b inst=%h required 0 %h", k, icache_if_miss_out, icache_if_inst_out, mem_word(32'h0000_2000));
         end
      end
      rdy_in = 1'b1;
      step();
      checks++;
      if (icache_if_miss_out !== 1'b1) begin
         errors++; $display("FAIL freeze_hit_dup miss=%b required 1", icache_if_miss_out);
      end
      issue(32'h0000_3000);
      rdy_in                 = 1'b0;
      memctrl_icache_rdy_in  = 1'b1;
      memctrl_icache_inst_in = mem_word(32'h0000_3000);
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (icache_memctrl_en_out !== 1'b1 || icache_if_rdy_out !== 1'b0 || icache_if_miss_out !== 1'b1) begin
            errors++; $display("FAIL freeze_miss cyc=%0d en=%b rdy=%b miss=%b required 1 0 1",
                               k, icache_memctrl_en_out, icache_if_rdy_out, icache_if_miss_out);
         end
      end
      rdy_in = 1'b1;
      step();
      memctrl_icache_rdy_in = 1'b0;
      checks++;
      if (icache_if_miss_out !== 1'b0 || icache_if_inst_out !== mem_word(32'h0000_3000) || icache_if_rdy_out !== 1'b1) begin
         errors++; $display("FAIL freeze_refill miss=%b inst=%h rdy=%b required 0 %h 1",
                            icache_if_miss_out, icache_if_inst_out, icache_if_rdy_out, mem_word(32'h0000_3000));
      end
      step();
      issue(32'h0000_3000);
      checks++;
      if (icache_if_miss_out !== 1'b0 || icache_if_inst_out !== mem_word(32'h0000_3000)) begin
         errors++; $display("FAIL freeze_fill_kept miss=%b inst=%h", icache_if_miss_out, icache_if_inst_out);
      end
      step();
   endtask

   task automatic test_reset_mid_miss();
      issue(32'h0000_5000);
      step();
      rst_in = 1'b1;
      step();
      rst_in = 1'b0;
      for (int i = 0; i < 256; i++) m_v[i] = 1'b0;
      checks++;
      if (icache_if_rdy_out !== 1'b1 || icache_if_miss_out !== 1'b1 || icache_if_inst_out !== 32'h0
          || icache_memctrl_en_out !== 1'b0 || icache_memctrl_addr_out !== 32'h0) begin
         errors++; $display("FAIL rst_mid rdy=%b miss=%b inst=%h en=%b addr=%h required 1 1 0 0 0", icache_if_rdy_out,
                            icache_if_miss_out, icache_if_inst_out, icache_memctrl_en_out, icache_memctrl_addr_out);
      end
      issue(32'h0000_3000);
      checks++;
      if (icache_if_miss_out !== 1'b1 || icache_memctrl_en_out !== 1'b1 || icache_memctrl_addr_out !== 32'h0000_3000) begin
         errors++; $display("FAIL rst_invalidate miss=%b en=%b addr=%h required 1 1 00003000",
                            icache_if_miss_out, icache_memctrl_en_out, icache_memctrl_addr_out);
      end
      refill(0, mem_word(32'h0000_3000));
      step();
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 150; n++) begin
         logic [31:0] a;
         logic [31:0] wa;
         logic [31:0] w;
         int          idx;
         int          lat;
         int          clr_at;
         bit          hit;
         bit          drop;
         a   = 32'h0001_0000 | ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
         wa  = a & 32'hFFFF_FFFC;
         w   = mem_word(a);
         idx = (a >> 2) % 256;
         if ($urandom_range(0, 7) == 0) begin
            memctrl_icache_rdy_in  = 1'b1;
            memctrl_icache_inst_in = $urandom;
            step();
            memctrl_icache_rdy_in  = 1'b0;
            checks++;
            if (icache_if_miss_out !== 1'b1 || icache_memctrl_en_out !== 1'b0) begin
               errors++; $display("FAIL rand_stray miss=%b en=%b required 1 0", icache_if_miss_out, icache_memctrl_en_out);
            end
         end
         if ($urandom_range(0, 9) == 0) begin
            rob_icache_clear_in = 1'b1;
            issue(a);
            rob_icache_clear_in = 1'b0;
            checks++;
            if (icache_if_miss_out !== 1'b1 || icache_memctrl_en_out !== 1'b0 || icache_if_rdy_out !== 1'b1) begin
               errors++; $display("FAIL rand_idle_clear miss=%b en=%b rdy=%b required 1 0 1",
                                  icache_if_miss_out, icache_memctrl_en_out, icache_if_rdy_out);
            end
         end
         hit = m_v[idx] && (m_addr[idx] == wa);
         issue(a);
         if (hit) begin
            checks++;
            if (icache_if_miss_out !== 1'b0 || icache_if_inst_out !== w || icache_memctrl_en_out !== 1'b0) begin
               errors++; $display("FAIL rand_hit addr=%h miss=%b inst=%h required 0 %h", a, icache_if_miss_out, icache_if_inst_out, w);
            end
         end else begin
            checks++;
            if (icache_if_miss_out !== 1'b1 || icache_if_rdy_out !== 1'b0 || icache_memctrl_en_out !== 1'b1
                || icache_memctrl_addr_out !== wa) begin
               errors++; $display("FAIL rand_miss addr=%h miss=%b rdy=%b en=%b maddr=%h required 1 0 1 %h",
                                  a, icache_if_miss_out, icache_if_rdy_out, icache_memctrl_en_out, icache_memctrl_addr_out, wa);
            end
            lat    = $urandom_range(0, 3);
            clr_at = $urandom_range(0, 7);
            drop   = (clr_at <= lat);
            for (int k = 0; k <= lat; k++) begin
               rob_icache_clear_in = (k == clr_at);
               if (k == lat) begin
                  memctrl_icache_rdy_in  = 1'b1;
                  memctrl_icache_inst_in = w;
               end
               step();
               rob_icache_clear_in   = 1'b0;
               memctrl_icache_rdy_in = 1'b0;
               if (k < lat) begin
                  checks++;
                  if (icache_memctrl_en_out !== 1'b1 || icache_memctrl_addr_out !== wa || icache_if_miss_out !== 1'b1) begin
                     errors++; $display("FAIL rand_wait addr=%h en=%b maddr=%h miss=%b", a, icache_memctrl_en_out, icache_memctrl_addr_out, icache_if_miss_out);
                  end
               end
            end
            checks++;
            if (icache_memctrl_en_out !== 1'b0 || icache_if_rdy_out !== 1'b1 || icache_if_miss_out !== drop
                || (!drop && icache_if_inst_out !== w)) begin
               errors++; $display("FAIL rand_fill addr=%h en=%b rdy=%b miss=%b inst=%h required 0 1 %b %h",
                                  a, icache_memctrl_en_out, icache_if_rdy_out, icache_if_miss_out, icache_if_inst_out, drop, w);
            end
            m_v[idx]    = 1'b1;
            m_addr[idx] = wa;
         end
         step();
         checks++;
         if (icache_if_miss_out !== 1'b1) begin
            errors++; $display("FAIL rand_pulse addr=%h miss=%b required 1", a, icache_if_miss_out);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      rst_in                 = 1'b1;
      rdy_in                 = 1'b1;
      if_icache_en_in        = 1'b0;
      if_icache_inst_addr_in = 32'h0;
      rob_icache_clear_in    = 1'b0;
      memctrl_icache_rdy_in  = 1'b0;
      memctrl_icache_inst_in = 32'h0;
      test_reset();
      test_first_miss();
      test_back_to_back();
      test_alias();
      test_clear();
      test_freeze();
      test_reset_mid_miss();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
